wb_ram_slave: RTL and testbench

Wishbone classic slave that sits directly downstream of the data-side Wishbone master. It consumes the master's single-word read and write cycles and serves them from an internal synchronous word RAM. A programmable wait-state counter models slow memory. Out-of-window addresses are acknowledged and flagged so that the master never hangs.

---
 rtl/wb_ram_slave_if.sv | 33 +++
 rtl/wb_ram_slave.sv | 181 ++++++++++++++++++
 tb/tb_wb_ram_slave.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_ram_slave_if.sv
// rtl/wb_ram_slave_if.sv - Wishbone classic bus bundle between data-side master and RAM slave
//
// Signals (directions given from the slave's point of view):
//   wbs_adr_i    in  32  byte address, bits [1:0] ignored
//   wbs_dat_i    in  32  write data
//   wbs_dat_o    out 32  read data, valid while wbs_ack_o=1
//   wbs_we_i     in  1   1=write, 0=read
//   wbs_sel_i    in  4   byte selects
//   wbs_cyc_i    in  1   bus cycle active
//   wbs_stb_i    in  1   strobe
//   wbs_ack_o    out 1   single-cycle acknowledge
//   range_err_o  out 1   pulse with ack for an out-of-window access
interface wb_ram_slave_if;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_ack_o;
  logic        range_err_o;

  modport master (
    output wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_sel_i, wbs_cyc_i, wbs_stb_i,
    input  wbs_dat_o, wbs_ack_o, range_err_o
  );

  modport slave (
    input  wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_sel_i, wbs_cyc_i, wbs_stb_i,
    output wbs_dat_o, wbs_ack_o, range_err_o
  );
endinterface

// File: rtl/wb_ram_slave.sv
// rtl/wb_ram_slave.sv - Wishbone classic slave serving single-word cycles from a synchronous RAM
//
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  synchronous active-high reset
//   wb   wb_ram_slave_if.slave  Wishbone slave bus (see rtl/wb_ram_slave_if.sv)
//
// Parameters:
//   ADDR_WIDTH   log2 of RAM depth in 32-bit words
//   BASE_ADDR    byte base address of the window, aligned to 4*2^ADDR_WIDTH
//   WAIT_STATES  extra cycles between request sample and ack (0..15)
//
// Optional feature macro WB_RAM_SLAVE_SEL_EN: when defined, writes honour
// wbs_sel_i byte lanes; when undefined, every write updates the full word.
module wb_ram_slave #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 2
) (
  input logic           clk,
  input logic           rst,
  wb_ram_slave_if.slave wb
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t state, state_d;
  logic [3:0] cnt, cnt_d;

  logic [31:0] mem [0:DEPTH-1];

  // Request fields captured at E0
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  we_q;
  logic                  hit_q;
  logic [31:0]           dat_q;
  logic [3:0]            sel_q;

  logic                  in_hit;
  logic [ADDR_WIDTH-1:0] in_idx;

  // Effective request: live bus in IDLE (only reaches ACK directly when
  // WAIT_STATES=0), otherwise the latched copy so late master changes are ignored.
  logic [ADDR_WIDTH-1:0] req_idx;
  logic                  req_we;
  logic                  req_hit;
  logic [31:0]           req_dat;
  logic [3:0]            req_sel;

  logic latch_en;
  logic access;      // this edge enters ACK and performs the RAM access

  logic ack_q;
  logic err_q;
  logic [31:0] rdata_q;

  assign in_idx = wb.wbs_adr_i[ADDR_WIDTH+1:2];
  assign in_hit = (wb.wbs_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);

  always_comb begin
    if (state == IDLE) begin
      req_idx = in_idx;
      req_we  = wb.wbs_we_i;
      req_hit = in_hit;
      req_dat = wb.wbs_dat_i;
      req_sel = wb.wbs_sel_i;
    end else begin
      req_idx = idx_q;
      req_we  = we_q;
      req_hit = hit_q;
      req_dat = dat_q;
      req_sel = sel_q;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    latch_en = 1'b0;
    access   = 1'b0;
    unique case (state)
      IDLE: begin
        if (wb.wbs_cyc_i && wb.wbs_stb_i) begin
          latch_en = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = ACK;
            access  = 1'b1;
          end else begin
            cnt_d   = WS_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!wb.wbs_cyc_i) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt == 4'd0) begin
          state_d = ACK;
          access  = 1'b1;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      ACK: begin
        // stb is still high here from the master's ack latency; ignore it.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (latch_en) begin
      idx_q <= in_idx;
      we_q  <= wb.wbs_we_i;
      hit_q <= in_hit;
      dat_q <= wb.wbs_dat_i;
      sel_q <= wb.wbs_sel_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      ack_q <= access;
      err_q <= access && !req_hit;
      if (access && !req_we) begin
        rdata_q <= req_hit ? mem[req_idx] : 32'h0;
      end
    end
  end

  // Reset gating keeps an in-flight write from landing during reset.
  always_ff @(posedge clk) begin
    if (access && req_we && req_hit && !rst) begin
`ifdef WB_RAM_SLAVE_SEL_EN
      for (int b = 0; b < 4; b++) begin
        if (req_sel[b]) begin
          mem[req_idx][8*b +: 8] <= req_dat[8*b +: 8];
        end
      end
`else
      mem[req_idx] <= req_dat;
`endif
    end
  end

`ifndef WB_RAM_SLAVE_SEL_EN
  logic unused_sel;
  assign unused_sel = ^req_sel;
`endif

  logic unused_adr;
  assign unused_adr = ^wb.wbs_adr_i[1:0];

  assign wb.wbs_ack_o   = ack_q;
  assign wb.range_err_o = err_q;
  assign wb.wbs_dat_o   = rdata_q;

endmodule

// File: tb/tb_wb_ram_slave.sv
// tb/tb_wb_ram_slave.sv - scoreboard bench for wb_ram_slave
module tb_wb_ram_slave;

  localparam int          AW   = 10;
  localparam int          WS   = 2;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_ram_slave_if bus ();

  wb_ram_slave #(
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (BASE),
    .WAIT_STATES(WS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_acks   = 0;
  int n_xfer   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic        we;
    logic [31:0] dat;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model[int];
  logic [31:0] last_rd = 32'h0;

  function automatic logic in_win(input logic [31:0] a);
    logic [31:0] b;
    b = BASE;
    return a[31:AW+2] == b[31:AW+2];
  endfunction

  // Monitor: pop one expectation per ack
  always @(negedge clk) begin
    exp_t e;
    if (bus.wbs_ack_o) begin
      n_acks++;
      if (sb.size() == 0) begin
        check("spurious_ack", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_err"}, 32'(bus.range_err_o), 32'(e.err));
        check({e.tag, "_dat"}, bus.wbs_dat_o, e.dat);
      end
    end
  end

  task automatic push_exp(input string tag, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
    exp_t        e;
    logic        hit;
    int          idx;
    logic [31:0] w;
    hit = in_win(adr);
    idx = int'(adr[AW+1:2]);
    e.tag = tag;
    e.we  = we;
    e.err = !hit;
    if (we) begin
      if (hit) begin
        w = model.exists(idx) ? model[idx] : 32'h0;
`ifdef WB_RAM_SLAVE_SEL_EN
        for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = dat[8*b +: 8];
`else
        w = dat;
`endif
        model[idx] = w;
      end
      e.dat = last_rd;
    end else begin
      e.dat   = hit ? model[idx] : 32'h0;
      last_rd = e.dat;
    end
    sb.push_back(e);
  endtask

  // Master-style transfer: stb held through the ack cycle, dropped one cycle later.
  task automatic xfer(input string tag, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel);
    int lat;
    bit got;
    push_exp(tag, we, adr, dat, sel);
    n_xfer++;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.wbs_ack_o) got = 1;
    end
    check({tag, "_lat"}, 32'(lat), 32'(WS + 1));
    @(posedge clk);
    #1;
    check({tag, "_ack_single"}, 32'(bus.wbs_ack_o), 32'd0);
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    logic [31:0] sel_exp;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
    check("rst_dat", bus.wbs_dat_o, 32'h0);
    check("rst_err", 32'(bus.range_err_o), 32'd0);
    check("rst_state", 32'(dut.state), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic write/read, back-to-back master handshake
    xfer("wr10", 1'b1, 32'h10, 32'hCAFE_BABE, 4'hF);
    xfer("rd10", 1'b0, 32'h10, 32'h0, 4'hF);
    xfer("wr14", 1'b1, 32'h14, 32'h0BAD_F00D, 4'hF);
    xfer("rd14", 1'b0, 32'h14, 32'h0, 4'hF);
    xfer("rd10b", 1'b0, 32'h10, 32'h0, 4'hF);

    // Out of window
    xfer("wr0", 1'b1, 32'h0, 32'hA5A5_A5A5, 4'hF);
    xfer("wr1000", 1'b1, 32'h1000, 32'hDEAD_BEEF, 4'hF);
    xfer("rd1000", 1'b0, 32'h1000, 32'h0, 4'hF);
    xfer("rd0", 1'b0, 32'h0, 32'h0, 4'hF);

    // Abort during WAIT
    xfer("wr20", 1'b1, 32'h20, 32'h1111_1111, 4'hF);
    bus.wbs_adr_i = 32'h20;
    bus.wbs_dat_i = 32'h1234_5678;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    a0 = n_acks;
    @(posedge clk);
    #1;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_noack", 32'(n_acks - a0), 32'd0);
    xfer("rd20_abort", 1'b0, 32'h20, 32'h0, 4'hF);

    // Reset while in WAIT
    xfer("wr30", 1'b1, 32'h30, 32'h2222_2222, 4'hF);
    xfer("rd30", 1'b0, 32'h30, 32'h0, 4'hF);
    bus.wbs_adr_i = 32'h30;
    bus.wbs_dat_i = 32'h3333_3333;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ack", 32'(bus.wbs_ack_o), 32'd0);
    check("midrst_dat", bus.wbs_dat_o, 32'h0);
    check("midrst_state", 32'(dut.state), 32'd0);
    rst = 1'b0;
    last_rd = 32'h0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    @(posedge clk);
    #1;
    xfer("rd30_rst", 1'b0, 32'h30, 32'h0, 4'hF);

    // Byte selects
    xfer("wr20_ff", 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF);
    xfer("wr20_sel", 1'b1, 32'h20, 32'h0000_0000, 4'b0101);
    xfer("rd20_sel", 1'b0, 32'h20, 32'h0, 4'hF);
`ifdef WB_RAM_SLAVE_SEL_EN
    sel_exp = 32'hFF00_FF00;
`else
    sel_exp = 32'h0000_0000;
`endif
    check("sel_literal", bus.wbs_dat_o, sel_exp);

    repeat (4) @(posedge clk);
    #1;
    check("ack_count", 32'(n_acks), 32'(n_xfer));
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
